// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one async SRAM between the CPU path and the debug port.
// Macro ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed CPU priority.
//
// Ports:
//   Clk, Reset          clock, async active-low reset
//   cpu_* / dbg_*       req/we/addr/wdata in, rdata/ack out (ack is a 1-cycle pulse)
//   Mem_ADDR, Mem_Dout  registered SRAM address and write data
//   Mem_Dout_en         pad driver enable
//   Mem_Din             data from the SRAM pads
//   Mem_CE/UB/LB/OE/WE  active-low SRAM strobes
//   busy, grant_dbg     FSM not idle, in-flight access owned by the debug port
module sram_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic [ADDR_W-1:0] Mem_ADDR,
  output logic [DATA_W-1:0] Mem_Dout,
  output logic              Mem_Dout_en,
  input  logic [DATA_W-1:0] Mem_Din,
  output logic              Mem_CE,
  output logic              Mem_UB,
  output logic              Mem_LB,
  output logic              Mem_OE,
  output logic              Mem_WE,
  output logic              busy,
  output logic              grant_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              wen_q, wen_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              gdbg_q, gdbg_d;
  logic              pick_dbg;
  logic              sel_we;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_q = 1 means the debug port won last; reset that way
  // so the CPU wins the first contested arbitration.
  logic last_grant_q, last_grant_d;

  always_comb begin
    pick_dbg = dbg_req & (~cpu_req | ~last_grant_q);
  end
`else
  always_comb begin
    pick_dbg = dbg_req & ~cpu_req;
  end
`endif

  always_comb begin
    sel_we = pick_dbg ? dbg_we : cpu_we;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_we_d     = op_we_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    dout_en_d   = dout_en_q;
    ce_d        = ce_q;
    oe_d        = oe_q;
    wen_d       = wen_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    gdbg_d      = gdbg_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cpu_req | dbg_req) begin
          state_d   = SETUP;
          gdbg_d    = pick_dbg;
          op_we_d   = sel_we;
          addr_d    = pick_dbg ? dbg_addr : cpu_addr;
          dout_d    = pick_dbg ? dbg_wdata : cpu_wdata;
          ce_d      = 1'b0;
          oe_d      = 1'b1;
          wen_d     = 1'b1;
          dout_en_d = sel_we;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_dbg;
`endif
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LAST;
        if (op_we_q) begin
          wen_d     = 1'b0;
          dout_en_d = 1'b1;
        end else begin
          oe_d = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: sample read data and raise ack for DONE.
          state_d   = DONE;
          oe_d      = 1'b1;
          wen_d     = 1'b1;
          cpu_ack_d = ~gdbg_q;
          dbg_ack_d = gdbg_q;
          if (!op_we_q) begin
            if (gdbg_q) dbg_rdata_d = Mem_Din;
            else        cpu_rdata_d = Mem_Din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // Write data stays driven through DONE for hold time.
        state_d   = IDLE;
        ce_d      = 1'b1;
        dout_en_d = 1'b0;
        gdbg_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_we_q     <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      ce_q        <= 1'b1;
      oe_q        <= 1'b1;
      wen_q       <= 1'b1;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      gdbg_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_we_q     <= op_we_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      dout_en_q   <= dout_en_d;
      ce_q        <= ce_d;
      oe_q        <= oe_d;
      wen_q       <= wen_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      gdbg_q      <= gdbg_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign Mem_ADDR    = addr_q;
  assign Mem_Dout    = dout_q;
  assign Mem_Dout_en = dout_en_q;
  assign Mem_CE      = ce_q;
  assign Mem_UB      = ce_q;
  assign Mem_LB      = ce_q;
  assign Mem_OE      = oe_q;
  assign Mem_WE      = wen_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dbg_rdata   = dbg_rdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign dbg_ack     = dbg_ack_q;
  assign busy        = (state_q != IDLE);
  assign grant_dbg   = gdbg_q;

endmodule
